ova_frame_crop: RTL

OVA_FRAME_CROP -- requirements
Module: ova_frame_crop

---
 rtl/ova_frame_crop_pkg.sv | 24 ++
 rtl/ova_frame_crop_rgb2gray.sv | 36 +++
 rtl/ova_frame_crop.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ova_frame_crop_pkg.sv
`default_nettype none
// Shared definitions for ova_frame_crop: state encoding, counter width, luma coefficients.
package ova_frame_crop_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  localparam logic [15:0] GRAY_KR = 16'd77;
  localparam logic [15:0] GRAY_KG = 16'd150;
  localparam logic [15:0] GRAY_KB = 16'd29;

  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t max);
    return (v >= max) ? max : cnt_t'(v + 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ova_frame_crop_rgb2gray.sv
`default_nettype none
// ova_rgb2gray: one-cycle RGB565 to 8-bit luma stage.
// Only built when OVA_CROP_GRAY_EN is defined.
`ifdef OVA_CROP_GRAY_EN
module ova_rgb2gray
  import ova_frame_crop_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] rgb,
  output logic [7:0]  y
);

  logic [7:0]  r8, g8, b8;
  logic [15:0] sum;

  // Replicate the top bits so full-scale 5/6-bit channels map to 255.
  always_comb begin
    r8  = {rgb[15:11], rgb[15:13]};
    g8  = {rgb[10:5],  rgb[10:9]};
    b8  = {rgb[4:0],   rgb[4:2]};
    sum = GRAY_KR * {8'h00, r8} + GRAY_KG * {8'h00, g8} + GRAY_KB * {8'h00, b8};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= 8'h00;
    end else if (en) begin
      y <= 8'(sum >> 8);
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/ova_frame_crop.sv
`default_nettype none
// ova_frame_crop: crops a window from a camera RGB565 stream into a write FIFO.
// Define OVA_CROP_GRAY_EN to emit {8'h00, luma} with 2-cycle latency instead of RGB565.
module ova_frame_crop
  import ova_frame_crop_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int CROP_X0 = 160,
  parameter int CROP_Y0 = 120,
  parameter int CROP_W  = 320,
  parameter int CROP_H  = 240
) (
  input  logic        i_pclk,
  input  logic        rst_n,
  input  logic [15:0] i_data,
  input  logic        i_data_vld,
  input  logic        href,
  input  logic        vsync,
  input  logic        i_fifo_full,
  output logic [15:0] o_wr_data,
  output logic        o_wr_en,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic        o_overflow
);

  localparam cnt_t COL_MAX = cnt_t'(IMG_W - 1);
  localparam cnt_t LIN_MAX = cnt_t'(IMG_H - 1);
  localparam cnt_t X_LO    = cnt_t'(CROP_X0);
  localparam cnt_t X_HI    = cnt_t'(CROP_X0 + CROP_W);
  localparam cnt_t Y_LO    = cnt_t'(CROP_Y0);
  localparam cnt_t Y_HI    = cnt_t'(CROP_Y0 + CROP_H);
  localparam cnt_t X_LAST  = cnt_t'(CROP_X0 + CROP_W - 1);
  localparam cnt_t Y_LAST  = cnt_t'(CROP_Y0 + CROP_H - 1);

  state_t state;
  logic   vsync_q, href_q;
  cnt_t   col, line, cur_col;
  logic   vs_rise, vs_fall, href_rise, href_fall;
  logic   col_inc, in_win, take, wr_ok, is_last, start_now;

  // A pixel arriving on the href rising cycle is column 0 of its line.
  always_comb begin
    vs_rise   = vsync & ~vsync_q;
    vs_fall   = ~vsync & vsync_q;
    href_rise = href & ~href_q;
    href_fall = ~href & href_q;
    cur_col   = href_rise ? '0 : col;
    col_inc   = i_data_vld & href & ~vsync;
    in_win    = (cur_col >= X_LO) && (cur_col < X_HI) && (line >= Y_LO) && (line < Y_HI);
    take      = (state == S_ACTIVE) && col_inc && in_win;
    wr_ok     = take && !i_fifo_full;
    is_last   = (line == Y_LAST) && (cur_col == X_LAST);
    start_now = (state == S_BLANK) && vs_fall;
  end

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      col           <= '0;
      line          <= '0;
      o_frame_start <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      href_q        <= href;
      o_frame_start <= start_now;
      case (state)
        S_IDLE:   if (vsync) state <= S_BLANK;
        S_BLANK:  if (vs_fall) state <= S_ACTIVE;
        S_ACTIVE: begin
          if (vs_rise) state <= S_BLANK;
          else if (take && i_fifo_full) state <= S_DROP;
        end
        S_DROP:   if (vs_rise) state <= S_BLANK;
        default:  state <= S_IDLE;
      endcase
      if (start_now) begin
        col        <= '0;
        line       <= '0;
        o_overflow <= 1'b0;
      end else begin
        if (take && i_fifo_full) o_overflow <= 1'b1;
        col <= col_inc ? sat_inc(cur_col, COL_MAX) : cur_col;
        if (href_fall) line <= sat_inc(line, LIN_MAX);
      end
    end
  end

`ifdef OVA_CROP_GRAY_EN
  logic       wr_q, last_q;
  logic [7:0] y;

  ova_rgb2gray u_rgb2gray (
    .clk   (i_pclk),
    .rst_n (rst_n),
    .en    (wr_ok),
    .rgb   (i_data),
    .y     (y)
  );

  // Strobe and done ride one stage behind the luma multiplier to stay aligned.
  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= 1'b0;
      last_q       <= 1'b0;
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      o_wr_data    <= 16'h0000;
    end else begin
      wr_q         <= wr_ok;
      last_q       <= wr_ok && is_last;
      o_wr_en      <= wr_q;
      o_frame_done <= last_q;
      if (wr_q) o_wr_data <= {8'h00, y};
    end
  end
`else
  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      o_wr_data    <= 16'h0000;
    end else begin
      o_wr_en      <= wr_ok;
      o_frame_done <= wr_ok && is_last;
      if (wr_ok) o_wr_data <= i_data;
    end
  end
`endif

endmodule
`default_nettype wire
